// File: rtl/draw_sched_pkg.sv
// draw_sched_pkg: shared types and defaults for the draw scheduler.
// Holds FSM encoding, default sizing, VGA field widths and pixel bundle.
package draw_sched_pkg;

  localparam int DEF_NUM_REQ          = 4;
  localparam int DEF_FRAME_CYCLES     = 833333;
  localparam int DEF_MAX_GRANT_CYCLES = 8192;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SNAP       = 2'd1,
    ST_GRANT      = 2'd2,
    ST_FRAME_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowest_one_hot.sv
// lowest_one_hot: isolates the lowest set bit of in_vec.
// Ports: in_vec (N) request vector, out_oh (N) one-hot or zero.
module lowest_one_hot #(
  parameter int N = 4
) (
  input  logic [N-1:0] in_vec,
  output logic [N-1:0] out_oh
);

  // Two's complement trick: x & -x keeps only the lowest one.
  assign out_oh = in_vec & (~in_vec + N'(1));

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame round of region redraws onto one VGA port.
// Ports: clk/reset, enable, req, pix_* per requester; gnt, frame_start,
//   plot/x/y/color_to_vga, busy, err_timeout, err_overrun.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_REQ          = DEF_NUM_REQ,
  parameter int FRAME_CYCLES     = DEF_FRAME_CYCLES,
  parameter int MAX_GRANT_CYCLES = DEF_MAX_GRANT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ-1:0]     pix_last,
  input  logic [NUM_REQ*X_W-1:0] pix_x,
  input  logic [NUM_REQ*Y_W-1:0] pix_y,
  input  logic [NUM_REQ*C_W-1:0] pix_colour,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   frame_start,
  output logic                   plot,
  output logic [X_W-1:0]         x_to_vga,
  output logic [Y_W-1:0]         y_to_vga,
  output logic [C_W-1:0]         color_to_vga,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_overrun
);

  localparam int FW = cnt_w(FRAME_CYCLES);
  localparam int WW = cnt_w(MAX_GRANT_CYCLES);
  localparam logic [FW-1:0] FC_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(MAX_GRANT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               frame_start_q, frame_start_d;
  logic               plot_q, plot_d;
  pix_t               pix_q, pix_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_overrun_q, err_overrun_d;

  logic [NUM_REQ-1:0] low_oh;
  logic [NUM_REQ-1:0] gnt_w;
  pix_t               sel_pix;
  logic               sel_valid;
  logic               sel_last;
  logic               fc_sat;
  logic               timeout;

  lowest_one_hot #(.N(NUM_REQ)) u_low (
    .in_vec (pending_q),
    .out_oh (low_oh)
  );

  assign gnt_w = (state_q == ST_GRANT) ? low_oh : '0;

  always_comb begin
    sel_pix = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_w[i]) begin
        sel_pix.x = pix_x[i*X_W +: X_W];
        sel_pix.y = pix_y[i*Y_W +: Y_W];
        sel_pix.c = pix_colour[i*C_W +: C_W];
      end
    end
  end

  assign sel_valid = |(gnt_w & pix_valid);
  assign sel_last  = |(gnt_w & pix_valid & pix_last);
  assign fc_sat    = (frame_cnt_q == FC_LAST);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    frame_cnt_d   = fc_sat ? frame_cnt_q : frame_cnt_q + FW'(1);
    wd_d          = '0;
    plot_d        = 1'b0;
    pix_d         = pix_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;
    timeout       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        frame_cnt_d = '0;
        if (enable) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        pending_d = req;
        state_d   = (|req) ? ST_GRANT : ST_FRAME_WAIT;
      end
      ST_GRANT: begin
        if (sel_valid) begin
          plot_d = 1'b1;
          pix_d  = sel_pix;
        end
        wd_d    = wd_q + WW'(1);
        timeout = !sel_last && (wd_q == WD_LAST);
        if (sel_last || timeout) begin
          pending_d = pending_q & ~gnt_w;
          wd_d      = '0;
          if (timeout) err_timeout_d = 1'b1;
          if (pending_d == '0) begin
            // Frame budget already spent: start the next pass at once.
            if (fc_sat) begin
              err_overrun_d = 1'b1;
              state_d = enable ? ST_SNAP : ST_IDLE;
            end else begin
              state_d = enable ? ST_FRAME_WAIT : ST_IDLE;
            end
          end
        end
      end
      ST_FRAME_WAIT: begin
        if (fc_sat) state_d = enable ? ST_SNAP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counting from the SNAP cycle keeps passes FRAME_CYCLES apart.
    if (state_d == ST_SNAP) frame_cnt_d = '0;
    frame_start_d = (state_d == ST_SNAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      frame_cnt_q   <= '0;
      wd_q          <= '0;
      frame_start_q <= 1'b0;
      plot_q        <= 1'b0;
      pix_q         <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      wd_q          <= wd_d;
      frame_start_q <= frame_start_d;
      plot_q        <= plot_d;
      pix_q         <= pix_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign gnt          = gnt_w;
  assign frame_start  = frame_start_q;
  assign plot         = plot_q;
  assign x_to_vga     = pix_q.x;
  assign y_to_vga     = pix_q.y;
  assign color_to_vga = pix_q.c;
  assign busy         = (state_q != ST_IDLE);
  assign err_timeout  = err_timeout_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of drawing requesters (0 = game board, 1 = next-shape box, 2 = time digits, 3 = score digits).
REQ-002 Parameter FRAME_CYCLES, default 833333: clk cycles per frame pass at 50 MHz.
REQ-003 Parameter MAX_GRANT_CYCLES, default 8192: watchdog limit per grant.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level; high permits frame passes (game started).
REQ-007 req  in  NUM_REQ  per-requester "redraw my region this frame".
REQ-008 pix_valid  in  NUM_REQ  requester i presents a pixel this cycle.
REQ-009 pix_last  in  NUM_REQ  qualifies pix_valid; final pixel of region.
REQ-010 pix_x  in  NUM_REQ*8;  pix_y  in  NUM_REQ*7;  pix_colour  in  NUM_REQ*3  packed per requester, slice i at [i*W +: W].
REQ-011 gnt  out  NUM_REQ  one-hot grant, or all zero.
REQ-012 frame_start  out  1  one-cycle pulse at the start of each pass.
REQ-013 plot  out  1;  x_to_vga  out  8;  y_to_vga  out  7;  color_to_vga  out  3  registered VGA write port.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 err_timeout  out  1;  err_overrun  out  1  sticky error flags.

Function
REQ-016 FSM states SHALL be IDLE, SNAP, GRANT, FRAME_WAIT.
REQ-017 IDLE: gnt=0, plot=0; enable=1 -> SNAP next cycle.
REQ-018 SNAP lasts one cycle: frame_start=1, pending<=req, frame_cnt<=0; next state is GRANT if req!=0, else FRAME_WAIT.
REQ-019 GRANT: gnt SHALL be the lowest-index set bit of pending.
REQ-020 A pixel on the granted index with pix_valid=1 SHALL appear on x/y/color_to_vga with plot=1 exactly one cycle later; in all other cycles plot=0 and x/y/colour hold.
REQ-021 pix_valid on non-granted indices SHALL be ignored.
REQ-022 pix_valid&pix_last on the granted index SHALL clear that pending bit; gnt moves to the next pending bit on the following cycle, or the FSM goes to FRAME_WAIT if none remain.
REQ-023 The watchdog SHALL count grant cycles and clear on every grant change; on reaching MAX_GRANT_CYCLES-1 without pix_last it SHALL clear the bit, set err_timeout, and advance as in REQ-022.
REQ-024 frame_cnt SHALL increment every cycle from SNAP and saturate at FRAME_CYCLES-1.
REQ-025 FRAME_WAIT: at frame_cnt==FRAME_CYCLES-1 -> SNAP if enable, else IDLE.
REQ-026 If the last region completes with frame_cnt already saturated, the FSM SHALL go to SNAP (or IDLE) directly and set err_overrun.
REQ-027 enable falling during GRANT SHALL NOT abort the pass; all pending regions finish, then -> IDLE.
REQ-028 req changes after SNAP SHALL NOT affect the current pass.

Reset
REQ-029 When reset is high at a clock edge, state SHALL become IDLE and pending, frame_cnt, watchdog, gnt, frame_start, plot, x/y/color_to_vga, err_timeout and err_overrun SHALL all be 0 at that edge, including mid-pass.
REQ-030 The error flags SHALL clear only on reset.

Structure
REQ-031 Package draw_sched_pkg SHALL hold the state encoding, the default NUM_REQ, FRAME_CYCLES and MAX_GRANT_CYCLES, and the VGA width constants (8/7/3).
REQ-032 Sub-module lowest_one_hot (NUM_REQ-wide, combinational) SHALL compute the grant vector from pending.

Verification
REQ-033 enable=1, req=4'b0011, req0 streams 3 pixels (last on 3rd), then req1 streams 2 -> frame_start pulse; gnt=0001 for 3 cycles, then 0010; 5 plot pulses each 1 cycle after valid, coordinates matching; then FRAME_WAIT.
REQ-034 FRAME_CYCLES=20, req=4'b0001 with a 4-pixel region -> frame_start pulses exactly 20 cycles apart; err_overrun=0.
REQ-035 MAX_GRANT_CYCLES=16, req0 never asserts pix_last -> gnt0 drops after 16 cycles; err_timeout=1; req1 is served next.
REQ-036 FRAME_CYCLES=8 with a 12-pixel region -> SNAP immediately after last; err_overrun=1.
REQ-037 reset asserted mid-GRANT -> at the next edge all outputs are 0 and state is IDLE; a pass restarts with a frame_start pulse after reset drops with enable=1.
REQ-038 enable dropped during region 0 of req=4'b0101 -> regions 0 and 2 both complete, then busy=0 and no further frame_start.
